y_reg_bank: RTL and testbench
=============================

// Module: y_reg_bank
// PURPOSE
//   Parametrised multi-entry successor to the single Y bus register: DEPTH registers of WIDTH
//   bits sharing one tristate DATA bus. Supports full load, sign- or zero-extended offset
//   load, and in-place increment/decrement, with per-entry valid tracking and sticky error
//   flags. Sits on the CPU data bus as operand/offset storage, driven by the control unit.
// PARAMETERS
//   WIDTH     16  register and bus width in bits
//   DEPTH     4   number of registers (>=2, power of two)
//   OFFSET_W  9   offset field width for extended loads (1..WIDTH-1)
//   ADDR_W    $clog2(DEPTH)  localparam, derived; not overridable
// PORTS
//   clk       in     1               single clock; all state updates on posedge
//   reset     in     1               synchronous, active-high
//   DATA      inout  WIDTH           shared bus; driven only while rd_en, else high-Z
//   wr_en     in     1               write/update strobe for entry wr_addr
//   wr_addr   in     ADDR_W          entry to update
//   wr_mode   in     2               00 LOAD, 01 SEXT, 10 ZEXT, 11 STEP (inc/dec)
//   step_dn   in     1               STEP direction: 0 = +1, 1 = -1
//   rd_en     in     1               drive entry rd_addr onto DATA
//   rd_addr   in     ADDR_W          entry to drive
//   err_clr   in     1               clears both sticky error flags
//   valid     out    DEPTH           per-entry written-since-reset flags
//   err_unwr  out    1               sticky: rd_en to an entry with valid=0
//   err_loop  out    1               sticky: illegal bus self-load (see below)
//   REG_OUT   out    DEPTH*WIDTH     debug view, entry i at [i*WIDTH +: WIDTH]
// BEHAVIOUR
//   Reset: all entries 0, valid 0, err_unwr 0, err_loop 0, DATA high-Z; reset overrides
//   all other inputs in that cycle, including any write in flight.
//   Read: combinational, zero latency; DATA = entry[rd_addr] while rd_en, else all Z.
//   Write, on the posedge when wr_en=1; valid[wr_addr] <= 1 for every mode:
//     LOAD  entry <= DATA
//     SEXT  entry <= {{(WIDTH-OFFSET_W){DATA[OFFSET_W-1]}}, DATA[OFFSET_W-1:0]}
//     ZEXT  entry <= {{(WIDTH-OFFSET_W){1'b0}}, DATA[OFFSET_W-1:0]}
//     STEP  entry <= entry +/- 1, mod 2^WIDTH (FFFF+1 -> 0000, 0000-1 -> FFFF); DATA ignored
//   Read-during-write, any addresses: DATA shows the pre-edge value; the new value is
//   visible from the next cycle.
//   Self-load: rd_en=1, wr_en=1, wr_mode != STEP (bank would load its own bus output).
//     The write is suppressed, valid is unchanged, err_loop <= 1.
//     STEP with rd_en=1 is legal for any addresses.
//   err_unwr <= 1 on any cycle where rd_en=1 and valid[rd_addr]=0; the bus is still
//   driven (with 0).
//   Error flags: err_clr clears both flags. If a set condition occurs in the same cycle as
//   err_clr, the set wins.
//   REG_OUT and valid are direct register outputs with no added latency.
// STRUCTURE
//   Shared package (cpu_pkg): wr_mode encodings (MODE_LOAD/SEXT/ZEXT/STEP) and the
//   extension function ext_offset(data, signed).
//   One natural sub-module: y_ext_unit, combinational SEXT/ZEXT/STEP next-value mux. The
//   storage array, valid bits, error logic and tristate driver stay in the top module.
// TESTING
//   1 reset; rd_en on addr 0 -> DATA=0000, err_unwr=1; err_clr -> 0; all valid=0.
//   2 LOAD 0x1234 to e1; SEXT 0x0100 to e2; ZEXT 0x01FF to e3 -> e1=1234, e2=FF00,
//     e3=01FF; valid=1110.
//   3 e0=FFFF, STEP up -> 0000; STEP down -> FFFF; STEP with rd_en on e0 shows old
//     value, no error.
//   4 rd_en e1 + wr_en LOAD e2 same cycle -> e2 unchanged, err_loop=1; err_clr with a
//     repeat of the same condition -> err_loop stays 1.
//   5 wr_en LOAD 0xBEEF with reset=1 -> entry=0, valid=0; DATA high-Z whenever rd_en=0.
//   6 Parameter sweep WIDTH=8, DEPTH=8, OFFSET_W=4: SEXT 0x08 -> 0xF8; REG_OUT slices
//     match each entry.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the Y register bank.
//   wr_mode_e  : write-mode encodings for the register bank update port
//   ext_offset : sign/zero-extends the low off_w bits of a value to EXT_MAX_W bits
package cpu_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_SEXT = 2'b01,
        MODE_ZEXT = 2'b10,
        MODE_STEP = 2'b11
    } wr_mode_e;

    // Widest register the extension helper can serve; callers slice down.
    localparam int EXT_MAX_W = 64;

    function automatic logic [EXT_MAX_W-1:0] ext_offset(
        input logic [EXT_MAX_W-1:0] data,
        input int                   off_w,
        input logic                 is_signed
    );
        logic [EXT_MAX_W-1:0] r_res;
        logic                 r_msb;
        r_res = '0;
        r_msb = 1'b0;
        for (int i = 0; i < EXT_MAX_W; i++) begin
            if (i == off_w - 1) r_msb = data[i];
        end
        for (int i = 0; i < EXT_MAX_W; i++) begin
            r_res[i] = (i < off_w) ? data[i] : (is_signed & r_msb);
        end
        return r_res;
    endfunction

endpackage

// File: rtl/y_ext_unit.sv
// Next-value selector for one register bank entry.
//   i_mode    : write mode (LOAD/SEXT/ZEXT/STEP)
//   i_step_dn : STEP direction, 0 = +1, 1 = -1
//   i_bus     : current value on the shared data bus
//   i_cur     : current contents of the entry being updated
//   o_next    : value the entry takes if the write is allowed
module y_ext_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int OFFSET_W = 9
) (
    input  logic [1:0]       i_mode,
    input  logic             i_step_dn,
    input  logic [WIDTH-1:0] i_bus,
    input  logic [WIDTH-1:0] i_cur,
    output logic [WIDTH-1:0] o_next
);

    logic [EXT_MAX_W-1:0] w_bus_wide;
    logic [EXT_MAX_W-1:0] w_sext;
    logic [EXT_MAX_W-1:0] w_zext;

    always_comb begin
        w_bus_wide = '0;
        w_bus_wide[WIDTH-1:0] = i_bus;
        w_sext = ext_offset(w_bus_wide, OFFSET_W, 1'b1);
        w_zext = ext_offset(w_bus_wide, OFFSET_W, 1'b0);
        o_next = i_bus;
        case (wr_mode_e'(i_mode))
            MODE_LOAD: o_next = i_bus;
            MODE_SEXT: o_next = w_sext[WIDTH-1:0];
            MODE_ZEXT: o_next = w_zext[WIDTH-1:0];
            // Natural wrap at WIDTH bits gives the modular step.
            MODE_STEP: o_next = i_step_dn ? (i_cur - 1'b1) : (i_cur + 1'b1);
            default:   o_next = i_bus;
        endcase
    end

endmodule

// File: rtl/y_reg_bank.sv
// Multi-entry Y register bank on a shared tristate data bus.
//   clk, reset : clock, synchronous active-high reset
//   DATA       : shared bus, driven with entry[rd_addr] while rd_en, else high-Z
//   wr_en/wr_addr/wr_mode/step_dn : update strobe, target entry, mode, step direction
//   rd_en/rd_addr : drive an entry onto DATA (combinational)
//   err_clr    : clears both sticky error flags (a same-cycle set wins)
//   valid      : per-entry written-since-reset flags
//   err_unwr   : sticky, read of a never-written entry
//   err_loop   : sticky, bank asked to load its own bus output
//   REG_OUT    : debug view, entry i at [i*WIDTH +: WIDTH]
module y_reg_bank
    import cpu_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 4,
    parameter  int OFFSET_W = 9,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    inout  wire  [WIDTH-1:0]       DATA,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [1:0]             wr_mode,
    input  logic                   step_dn,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   err_clr,
    output logic [DEPTH-1:0]       valid,
    output logic                   err_unwr,
    output logic                   err_loop,
    output logic [DEPTH*WIDTH-1:0] REG_OUT
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic             r_err_unwr;
    logic             r_err_loop;

    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_next;
    logic             w_self_load;
    logic             w_rd_unwr;

    assign w_rd_data = r_mem[rd_addr];
    assign DATA      = rd_en ? w_rd_data : {WIDTH{1'bz}};

    // With rd_en high the bus carries our own output; only STEP ignores the bus.
    assign w_self_load = rd_en & wr_en & (wr_mode != MODE_STEP);
    assign w_rd_unwr   = rd_en & ~r_valid[rd_addr];

    y_ext_unit #(
        .WIDTH    (WIDTH),
        .OFFSET_W (OFFSET_W)
    ) u_ext (
        .i_mode    (wr_mode),
        .i_step_dn (step_dn),
        .i_bus     (DATA),
        .i_cur     (r_mem[wr_addr]),
        .o_next    (w_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_valid    <= '0;
            r_err_unwr <= 1'b0;
            r_err_loop <= 1'b0;
        end else begin
            if (wr_en && !w_self_load) begin
                r_mem[wr_addr]   <= w_next;
                r_valid[wr_addr] <= 1'b1;
            end
            if (w_rd_unwr)    r_err_unwr <= 1'b1;
            else if (err_clr) r_err_unwr <= 1'b0;
            if (w_self_load)  r_err_loop <= 1'b1;
            else if (err_clr) r_err_loop <= 1'b0;
        end
    end

    assign valid    = r_valid;
    assign err_unwr = r_err_unwr;
    assign err_loop = r_err_loop;

    for (genvar g = 0; g < DEPTH; g++) begin : g_dbg
        assign REG_OUT[g*WIDTH +: WIDTH] = r_mem[g];
    end

endmodule

// File: tb/tb_y_reg_bank.sv
module tb_y_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // DUT A: default parameters (16/4/9)
    logic        rst_a = 1'b1, we_a = 1'b0, dn_a = 1'b0, re_a = 1'b0, ec_a = 1'b0, oe_a = 1'b0;
    logic [1:0]  wm_a = 2'd0, wa_a = 2'd0, ra_a = 2'd0;
    logic [15:0] drv_a = 16'd0;
    wire  [15:0] data_a;
    logic [3:0]  valid_a;
    logic        unwr_a, loop_a;
    logic [63:0] regout_a;
    assign data_a = oe_a ? drv_a : 16'hzzzz;

    y_reg_bank dut_a (
        .clk(clk), .reset(rst_a), .DATA(data_a), .wr_en(we_a), .wr_addr(wa_a),
        .wr_mode(wm_a), .step_dn(dn_a), .rd_en(re_a), .rd_addr(ra_a), .err_clr(ec_a),
        .valid(valid_a), .err_unwr(unwr_a), .err_loop(loop_a), .REG_OUT(regout_a)
    );

    // DUT B: 8-bit, 8 entries, 4-bit offset
    logic        rst_b = 1'b1, we_b = 1'b0, dn_b = 1'b0, re_b = 1'b0, ec_b = 1'b0, oe_b = 1'b0;
    logic [1:0]  wm_b = 2'd0;
    logic [2:0]  wa_b = 3'd0, ra_b = 3'd0;
    logic [7:0]  drv_b = 8'd0;
    wire  [7:0]  data_b;
    logic [7:0]  valid_b;
    logic        unwr_b, loop_b;
    logic [63:0] regout_b;
    assign data_b = oe_b ? drv_b : 8'hzz;

    y_reg_bank #(.WIDTH(8), .DEPTH(8), .OFFSET_W(4)) dut_b (
        .clk(clk), .reset(rst_b), .DATA(data_b), .wr_en(we_b), .wr_addr(wa_b),
        .wr_mode(wm_b), .step_dn(dn_b), .rd_en(re_b), .rd_addr(ra_b), .err_clr(ec_b),
        .valid(valid_b), .err_unwr(unwr_b), .err_loop(loop_b), .REG_OUT(regout_b)
    );

    // Reference state: plain integers per entry plus flags.
    longint unsigned ma[4], mb[8];
    bit              va[4], vb[8];
    bit              ua, la, ub, lb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value an entry takes for a given mode, from the arithmetic definition.
    function automatic longint unsigned nextval(input int mode, input longint unsigned cur,
                                                input longint unsigned bus, input bit dn,
                                                input int w, input int o);
        longint unsigned m, lo;
        m  = 64'd1 << w;
        lo = bus % (64'd1 << o);
        case (mode)
            0:       return bus % m;
            1:       return (lo >= (64'd1 << (o - 1))) ? lo + m - (64'd1 << o) : lo;
            2:       return lo;
            default: return dn ? (cur + m - 1) % m : (cur + 1) % m;
        endcase
    endfunction

    task automatic cyc_a(input bit rst, input bit we, input int wm, input int wa, input bit dn,
                         input bit re, input int ra, input bit ec, input logic [15:0] drv);
        bit su, sl;
        longint unsigned nv;
        logic [63:0] e;
        rst_a = rst; we_a = we; wm_a = wm[1:0]; wa_a = wa[1:0]; dn_a = dn;
        re_a = re; ra_a = ra[1:0]; ec_a = ec; drv_a = drv; oe_a = !re;
        #1;
        if (re) chk("A_rd_data", {48'd0, data_a}, ma[ra]);
        else    chk("A_bus_released", {48'd0, data_a}, {48'd0, drv});
        nv = nextval(wm, ma[wa], drv, dn, 16, 9);
        su = re && !va[ra];
        sl = re && we && (wm != 3);
        @(posedge clk); #1;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin ma[i] = 0; va[i] = 0; end
            ua = 0; la = 0;
        end else begin
            if (we && !sl) begin ma[wa] = nv; va[wa] = 1; end
            ua = su ? 1'b1 : (ec ? 1'b0 : ua);
            la = sl ? 1'b1 : (ec ? 1'b0 : la);
        end
        e = '0;
        for (int i = 0; i < 4; i++) e[i*16 +: 16] = ma[i][15:0];
        chk("A_reg_out", regout_a, e);
        e = '0;
        for (int i = 0; i < 4; i++) e[i] = va[i];
        chk("A_valid", {60'd0, valid_a}, e);
        chk("A_err_unwr", {63'd0, unwr_a}, {63'd0, ua});
        chk("A_err_loop", {63'd0, loop_a}, {63'd0, la});
    endtask

    task automatic cyc_b(input bit rst, input bit we, input int wm, input int wa, input bit dn,
                         input bit re, input int ra, input bit ec, input logic [7:0] drv);
        bit su, sl;
        longint unsigned nv;
        logic [63:0] e;
        rst_b = rst; we_b = we; wm_b = wm[1:0]; wa_b = wa[2:0]; dn_b = dn;
        re_b = re; ra_b = ra[2:0]; ec_b = ec; drv_b = drv; oe_b = !re;
        #1;
        if (re) chk("B_rd_data", {56'd0, data_b}, mb[ra]);
        else    chk("B_bus_released", {56'd0, data_b}, {56'd0, drv});
        nv = nextval(wm, mb[wa], drv, dn, 8, 4);
        su = re && !vb[ra];
        sl = re && we && (wm != 3);
        @(posedge clk); #1;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin mb[i] = 0; vb[i] = 0; end
            ub = 0; lb = 0;
        end else begin
            if (we && !sl) begin mb[wa] = nv; vb[wa] = 1; end
            ub = su ? 1'b1 : (ec ? 1'b0 : ub);
            lb = sl ? 1'b1 : (ec ? 1'b0 : lb);
        end
        e = '0;
        for (int i = 0; i < 8; i++) e[i*8 +: 8] = mb[i][7:0];
        chk("B_reg_out", regout_b, e);
        e = '0;
        for (int i = 0; i < 8; i++) e[i] = vb[i];
        chk("B_valid", {56'd0, valid_b}, e);
        chk("B_err_unwr", {63'd0, unwr_b}, {63'd0, ub});
        chk("B_err_loop", {63'd0, loop_b}, {63'd0, lb});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin ma[i] = 0; va[i] = 0; end
        for (int i = 0; i < 8; i++) begin mb[i] = 0; vb[i] = 0; end
        ua = 0; la = 0; ub = 0; lb = 0;

        // reset, unwritten read, error clear
        cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        cyc_a(0, 0, 0, 0, 0, 1, 0, 0, 16'h0000);
        chk("A_unwr_after_read", {63'd0, unwr_a}, 64'd1);
        cyc_a(0, 0, 0, 0, 0, 0, 0, 1, 16'h5A5A);

        // LOAD / SEXT / ZEXT
        cyc_a(0, 1, 0, 1, 0, 0, 0, 0, 16'h1234);
        cyc_a(0, 1, 1, 2, 0, 0, 0, 0, 16'h0100);
        cyc_a(0, 1, 2, 3, 0, 0, 0, 0, 16'h01FF);
        chk("A_sext_e2", {48'd0, regout_a[47:32]}, 64'hFF00);
        chk("A_valid_1110", {60'd0, valid_a}, 64'hE);

        // STEP wrap both ways, STEP during read of same entry
        cyc_a(0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF);
        cyc_a(0, 1, 3, 0, 0, 0, 0, 0, 16'h1111);
        chk("A_wrap_up", {48'd0, regout_a[15:0]}, 64'h0000);
        cyc_a(0, 1, 3, 0, 1, 0, 0, 0, 16'h2222);
        chk("A_wrap_dn", {48'd0, regout_a[15:0]}, 64'hFFFF);
        cyc_a(0, 1, 3, 0, 0, 1, 0, 0, 16'h0000);

        // self-load suppression and set-beats-clear
        cyc_a(0, 1, 0, 2, 0, 1, 1, 0, 16'h0000);
        cyc_a(0, 1, 0, 2, 0, 1, 1, 1, 16'h0000);
        chk("A_loop_sticky", {63'd0, loop_a}, 64'd1);
        cyc_a(0, 0, 0, 0, 0, 0, 0, 1, 16'hA5A5);

        // reset overrides an in-flight write; bus released when idle
        cyc_a(1, 1, 0, 1, 0, 0, 0, 0, 16'hBEEF);
        chk("A_reset_valid", {60'd0, valid_a}, 64'd0);
        cyc_a(0, 1, 0, 0, 0, 0, 0, 0, 16'h00C3);
        cyc_a(0, 0, 0, 0, 0, 0, 0, 0, 16'hFF3C);

        for (int n = 0; n < 250; n++) begin
            cyc_a(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), 16'($urandom));
        end

        // narrow configuration
        cyc_b(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        cyc_b(0, 1, 1, 5, 0, 0, 0, 0, 8'h08);
        chk("B_sext_08", {56'd0, regout_b[47:40]}, 64'hF8);
        cyc_b(0, 1, 2, 7, 0, 0, 0, 0, 8'hFF);
        cyc_b(0, 1, 3, 7, 1, 1, 5, 0, 8'h00);
        for (int n = 0; n < 200; n++) begin
            cyc_b(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
